// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//  Shared types and helpers for the parametrised memory controller.
//  state_e : controller FSM state (CLEAR sweeps the array to zero, RUN serves
//            requests).
//  lanes() : number of byte lanes in a data word.
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// -----------------------------------------------------------------------------
// mem_clear_seq
//  Index generator for the hardware clear sweep. While 'active' is high the
//  index walks 0..DEPTH-1, one word per cycle; 'done' flags the final index so
//  the controller can leave its clear state on the same edge that writes the
//  last word. Whenever 'active' is low the index is parked at 0, so every new
//  sweep starts from the first word.
// Ports:
//  clk     in   clock, rising edge
//  rst_n   in   asynchronous active-low reset
//  active  in   clear sweep in progress
//  idx     out  word index to clear this cycle
//  done    out  idx is the last word of the array
// -----------------------------------------------------------------------------
module mem_clear_seq #(
    parameter int DEPTH    = 32,
    parameter int ADDR_WID = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                active,
    output logic [ADDR_WID-1:0] idx,
    output logic                done
);

    localparam logic [ADDR_WID-1:0] LAST_IDX = ADDR_WID'(DEPTH - 1);

    logic [ADDR_WID-1:0] idx_r;

    assign idx  = idx_r;
    assign done = active && (idx_r == LAST_IDX);

    // Sweep counter: advance while clearing, return to 0 after the last word or when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if (active && !done) begin
            idx_r <= idx_r + ADDR_WID'(1);
        end else begin
            idx_r <= '0;
        end
    end

endmodule

// File: rtl/param_mem_ctrl.sv
// -----------------------------------------------------------------------------
// param_mem_ctrl
//  Single-port word memory behind a valid/ready request port, with per-byte
//  write enables, a 1- or 2-cycle read pipeline and a hardware clear sweep
//  that runs after reset and on clr_start.
// Ports:
//  clk        in   clock, rising edge
//  rst_n      in   asynchronous active-low reset
//  req_valid  in   request present
//  req_ready  out  request can be accepted (controller in RUN)
//  req_we     in   1 = write, 0 = read
//  req_addr   in   word address
//  req_wdata  in   write data
//  req_be     in   byte enables for writes
//  rsp_valid  out  one-cycle pulse per read, READ_LATENCY cycles after accept
//  rsp_rdata  out  read data, held between responses
//  clr_start  in   start a full clear sweep (honoured in RUN only)
//  busy       out  clear sweep in progress
//  err        out  one-cycle pulse: an accepted request addressed >= DEPTH
// -----------------------------------------------------------------------------
module param_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int ADDR_WID     = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WID-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    clr_start,
    output logic                    busy,
    output logic                    err
);

    localparam int                LANES   = lanes(DATA_WIDTH);
    // DEPTH widened by one bit so the range check also works for power-of-two depths.
    localparam logic [ADDR_WID:0] DEPTH_W = (ADDR_WID + 1)'(DEPTH);

    state_e                state_r;
    state_e                state_nxt;
    logic [ADDR_WID-1:0]   clr_idx;
    logic                  clr_done;
    logic                  addr_ok;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_v1_r;
    logic [DATA_WIDTH-1:0] rd_d1_r;
    logic                  err_r;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mem_clear_seq #(
        .DEPTH    (DEPTH),
        .ADDR_WID (ADDR_WID)
    ) u_clear_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (state_r == CLEAR),
        .idx    (clr_idx),
        .done   (clr_done)
    );

    assign req_ready = (state_r == RUN);
    assign busy      = (state_r == CLEAR);
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);
    assign accept    = req_valid && (state_r == RUN);
    assign rd_accept = accept && !req_we;
    // Out-of-range writes are accepted (and flagged) but never touch the array.
    assign wr_accept = accept && req_we && addr_ok;

    // Next-state logic: sweep until the last word is cleared, re-enter the sweep on clr_start.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            CLEAR: begin
                if (clr_done) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = CLEAR;
                end
            end
            RUN: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // State register: reset lands in CLEAR so the array is swept before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CLEAR;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Storage: clear sweep writes zero; otherwise accepted writes update enabled byte lanes.
    always_ff @(posedge clk) begin
        if (state_r == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word selection: out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            rd_word = mem[req_addr];
        end else begin
            rd_word = '0;
        end
    end

    // First read stage and error flag: data is captured at the accepting edge, so a
    // later clear cannot disturb a read that was already accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_r <= 1'b0;
            rd_d1_r <= '0;
            err_r   <= 1'b0;
        end else begin
            rd_v1_r <= rd_accept;
            err_r   <= accept && !addr_ok;
            if (rd_accept) begin
                rd_d1_r <= rd_word;
            end
        end
    end

    assign err = err_r;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2_r;
            logic [DATA_WIDTH-1:0] rd_d2_r;

            // Second read stage: data only advances with a valid beat so the output holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2_r <= 1'b0;
                    rd_d2_r <= '0;
                end else begin
                    rd_v2_r <= rd_v1_r;
                    if (rd_v1_r) begin
                        rd_d2_r <= rd_d1_r;
                    end
                end
            end

            assign rsp_valid = rd_v2_r;
            assign rsp_rdata = rd_d2_r;
        end else begin : g_lat1
            assign rsp_valid = rd_v1_r;
            assign rsp_rdata = rd_d1_r;
        end
    endgenerate

endmodule
